// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: state encoding, fault codes,
// and the width of the wait-state counter.
// No ports (package).
package mem_pkg;

    localparam int WAIT_W = 3;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    localparam logic [1:0] FAULT_RANGE = 2'b01;
    localparam logic [1:0] FAULT_BOTH  = 2'b10;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DATA_W x 2**DEPTH_LOG2, registered read port.
// Ports:
//   CLK     clock, rising edge
//   Reset   async active-high; clears only the read register, never the array
//   WrEn    write the array at Addr with WrData
//   RdEn    load RdData from the array at Addr
//   Addr    word address
//   WrData  write data
//   RdData  registered read data, held until the next RdEn
module mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [DEPTH_LOG2-1:0] Addr,
    input  logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     RdData
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (WrEn) begin
            mem[Addr] <= WrData;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RdData <= '0;
        end else if (RdEn) begin
            RdData <= mem[Addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts single-cycle MemRead/MemWrite strobes, inserts
// WAIT_CYCLES wait states, accesses the internal RAM and returns a one-cycle
// MemReady. Malformed or out-of-range requests complete as a fault.
// Ports:
//   CLK, Reset        clock (rising edge), async active-high reset
//   MemRead/MemWrite  request strobes, sampled at a CLK edge while idle
//   Address           word address, sampled with the strobe
//   WriteData         write data, sampled with the strobe
//   ReadData          last completed read value
//   MemReady          one-cycle completion pulse (read, write or fault)
//   MemBusy           high whenever the responder is not idle
//   AddrFault         one-cycle fault pulse, coincident with MemReady
//   FaultCode         01 out-of-range, 10 both strobes; held until next fault
//   FaultAddr         address of the last faulting request
//   Overrun           sticky: a strobe arrived while busy
//
// state   | meaning
// IDLE    | waiting for a strobe
// ACCESS  | counting wait states; RAM op issued when count reaches 0
// RESPOND | MemReady pulse, ReadData valid for reads
// FAULT   | MemReady + AddrFault pulse, no RAM access
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemBusy,
    output logic              AddrFault,
    output logic [1:0]        FaultCode,
    output logic [ADDR_W-1:0] FaultAddr,
    output logic              Overrun
);

    import mem_pkg::*;

    logic [1:0]            state;
    logic [WAIT_W-1:0]     count;
    logic                  opWrite;
    logic [DEPTH_LOG2-1:0] addrReg;
    logic [DATA_W-1:0]     dataReg;

    logic anyStrobe;
    logic bothStrobe;
    logic inRange;
    logic ramFire;

    assign anyStrobe  = MemRead | MemWrite;
    assign bothStrobe = MemRead & MemWrite;
    // Shift rather than slice so ADDR_W == DEPTH_LOG2 degenerates to "always in range".
    assign inRange    = (Address >> DEPTH_LOG2) == '0;
    assign ramFire    = (state == ACCESS) && (count == '0);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            opWrite   <= 1'b0;
            addrReg   <= '0;
            dataReg   <= '0;
            FaultCode <= '0;
            FaultAddr <= '0;
            Overrun   <= 1'b0;
        end else begin
            if (anyStrobe && (state != IDLE)) begin
                Overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bothStrobe) begin
                        state     <= FAULT;
                        FaultCode <= FAULT_BOTH;
                        FaultAddr <= Address;
                    end else if (anyStrobe && !inRange) begin
                        state     <= FAULT;
                        FaultCode <= FAULT_RANGE;
                        FaultAddr <= Address;
                    end else if (anyStrobe) begin
                        state   <= ACCESS;
                        opWrite <= MemWrite;
                        addrReg <= Address[DEPTH_LOG2-1:0];
                        dataReg <= WriteData;
                        count   <= WAIT_W'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        state <= RESPOND;
                    end else begin
                        count <= count - WAIT_W'(1);
                    end
                end
                RESPOND: state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MemReady  = (state == RESPOND) || (state == FAULT);
    assign AddrFault = (state == FAULT);
    assign MemBusy   = (state != IDLE);

    // ReadData is the RAM's read register itself, so it only moves on reads.
    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uArray (
        .CLK    (CLK),
        .Reset  (Reset),
        .WrEn   (ramFire & opWrite),
        .RdEn   (ramFire & ~opWrite),
        .Addr   (addrReg),
        .WrData (dataReg),
        .RdData (ReadData)
    );

endmodule
